// File: rtl/alien_march_ctrl.sv
// alien_march_ctrl: steps the alien formation origin once every N frames.
// N = 1 + (live aliens / 4), so the march speeds up as aliens die.
// On each step a 10-cycle column scan of a snapshot of the live-alien map
// finds the live left/right edge, the bottom row and the live count.
// The formation reverses and descends at a screen border.
// It stops with WaveClear when no aliens remain, or with Invaded when the
// formation bottom reaches the player row.
//
// Ports:
//   Clk          system clock
//   Reset        asynchronous active-low reset
//   Start        one-cycle pulse, starts a new wave from any state
//   FrameTick    one-cycle pulse per video frame
//   Aliens_Grid  live-alien map, bit r*10+c = row r, column c
//   PlayerRow    invasion line (pixel row)
//   AliensRow    formation origin row
//   AliensCol    formation origin column
//   Dir          1 = moving right, 0 = moving left
//   StepPulse    one-cycle pulse on each position update
//   WaveClear    level, no live aliens remain
//   Invaded      level, formation bottom reached PlayerRow
module alien_march_ctrl #(
    parameter int unsigned START_ROW = 32,
    parameter int unsigned START_COL = 64,
    parameter int unsigned ALIEN_W   = 32,
    parameter int unsigned ALIEN_H   = 24,
    parameter int unsigned STEP_X    = 4,
    parameter int unsigned STEP_Y    = 16,
    parameter int unsigned SCREEN_W  = 640
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        FrameTick,
    input  logic [49:0] Aliens_Grid,
    input  logic [8:0]  PlayerRow,
    output logic [8:0]  AliensRow,
    output logic [9:0]  AliensCol,
    output logic        Dir,
    output logic        StepPulse,
    output logic        WaveClear,
    output logic        Invaded
);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StScan,
        StDecide,
        StClear,
        StInvaded
    } state_e;

    state_e            r_state, w_state_d;
    logic [8:0]        r_row, w_row_d;
    logic [9:0]        r_col, w_col_d;
    logic              r_dir, w_dir_d;
    logic              r_step, w_step_d;
    logic              r_clear, w_clear_d;
    logic              r_inv, w_inv_d;
    logic [3:0]        r_frame, w_frame_d;
    logic [5:0]        r_alive, w_alive_d;
    // Snapshot kept as 5 rows of 10 columns so a column is one bit per row.
    logic [4:0][9:0]   r_snap, w_snap_d;
    logic [3:0]        r_scan_c, w_scan_c_d;
    logic [3:0]        r_left, w_left_d;
    logic [3:0]        r_right, w_right_d;
    logic              r_found, w_found_d;
    logic [4:0]        r_mask, w_mask_d;
    logic [5:0]        r_acc, w_acc_d;

    logic [3:0]        w_interval;
    logic [4:0]        w_col_bits;
    logic              w_col_alive;
    logic [2:0]        w_col_pop;
    logic [2:0]        w_bottom;
    logic [10:0]       w_l;
    logic [10:0]       w_r;
    logic [10:0]       w_row_new;
    logic              w_descend;
    logic              w_inv_hit;

    assign w_interval = 4'd1 + 4'(r_alive >> 2);

    assign w_col_bits = {r_snap[4][r_scan_c], r_snap[3][r_scan_c], r_snap[2][r_scan_c],
                         r_snap[1][r_scan_c], r_snap[0][r_scan_c]};
    assign w_col_alive = |w_col_bits;
    assign w_col_pop   = 3'(w_col_bits[0]) + 3'(w_col_bits[1]) + 3'(w_col_bits[2])
                       + 3'(w_col_bits[3]) + 3'(w_col_bits[4]);

    always_comb begin
        w_bottom = 3'd0;
        if (r_mask[4])      w_bottom = 3'd4;
        else if (r_mask[3]) w_bottom = 3'd3;
        else if (r_mask[2]) w_bottom = 3'd2;
        else if (r_mask[1]) w_bottom = 3'd1;
    end

    // Edge and invasion arithmetic is 11 bits wide so sums never wrap.
    assign w_l       = 11'(r_col) + 11'(r_left) * 11'(ALIEN_W);
    assign w_r       = 11'(r_col) + (11'(r_right) + 11'd1) * 11'(ALIEN_W);
    assign w_row_new = 11'(r_row) + 11'(STEP_Y);
    assign w_descend = r_dir ? ((w_r + 11'(STEP_X)) > 11'(SCREEN_W))
                             : (w_l < 11'(STEP_X));
    assign w_inv_hit = (11'(w_row_new[8:0]) + (11'(w_bottom) + 11'd1) * 11'(ALIEN_H))
                       >= 11'(PlayerRow);

    always_comb begin
        w_state_d  = r_state;
        w_row_d    = r_row;
        w_col_d    = r_col;
        w_dir_d    = r_dir;
        w_step_d   = 1'b0;
        w_clear_d  = r_clear;
        w_inv_d    = r_inv;
        w_frame_d  = r_frame;
        w_alive_d  = r_alive;
        w_snap_d   = r_snap;
        w_scan_c_d = r_scan_c;
        w_left_d   = r_left;
        w_right_d  = r_right;
        w_found_d  = r_found;
        w_mask_d   = r_mask;
        w_acc_d    = r_acc;

        case (r_state)
            StIdle: ;
            StWait: begin
                if (FrameTick) begin
                    if ((r_frame + 4'd1) >= w_interval) begin
                        w_frame_d  = 4'd0;
                        w_state_d  = StScan;
                        w_snap_d   = Aliens_Grid;
                        w_scan_c_d = 4'd0;
                        w_left_d   = 4'd0;
                        w_right_d  = 4'd0;
                        w_found_d  = 1'b0;
                        w_mask_d   = 5'd0;
                        w_acc_d    = 6'd0;
                    end else begin
                        w_frame_d = r_frame + 4'd1;
                    end
                end
            end
            StScan: begin
                if (w_col_alive) begin
                    if (!r_found) begin
                        w_left_d = r_scan_c;
                    end
                    w_right_d = r_scan_c;
                    w_found_d = 1'b1;
                end
                w_mask_d = r_mask | w_col_bits;
                w_acc_d  = r_acc + {3'b000, w_col_pop};
                if (r_scan_c == 4'd9) begin
                    w_state_d = StDecide;
                end else begin
                    w_scan_c_d = r_scan_c + 4'd1;
                end
            end
            StDecide: begin
                w_alive_d = r_acc;
                if (r_acc == 6'd0) begin
                    w_state_d = StClear;
                    w_clear_d = 1'b1;
                end else begin
                    w_step_d = 1'b1;
                    if (w_descend) begin
                        w_row_d = w_row_new[8:0];
                        w_dir_d = ~r_dir;
                        if (w_inv_hit) begin
                            w_state_d = StInvaded;
                            w_inv_d   = 1'b1;
                        end else begin
                            w_state_d = StWait;
                        end
                    end else begin
                        w_col_d   = r_dir ? (r_col + 10'(STEP_X)) : (r_col - 10'(STEP_X));
                        w_state_d = StWait;
                    end
                end
            end
            StClear, StInvaded: ;
            default: w_state_d = StIdle;
        endcase

        // Start overrides everything, including a same-cycle FrameTick.
        if (Start) begin
            w_state_d  = StWait;
            w_row_d    = 9'(START_ROW);
            w_col_d    = 10'(START_COL);
            w_dir_d    = 1'b1;
            w_step_d   = 1'b0;
            w_clear_d  = 1'b0;
            w_inv_d    = 1'b0;
            w_frame_d  = 4'd0;
            w_alive_d  = 6'd50;
            w_scan_c_d = 4'd0;
            w_found_d  = 1'b0;
            w_mask_d   = 5'd0;
            w_acc_d    = 6'd0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state  <= StIdle;
            r_row    <= 9'(START_ROW);
            r_col    <= 10'(START_COL);
            r_dir    <= 1'b1;
            r_step   <= 1'b0;
            r_clear  <= 1'b0;
            r_inv    <= 1'b0;
            r_frame  <= 4'd0;
            r_alive  <= 6'd50;
            r_snap   <= '0;
            r_scan_c <= 4'd0;
            r_left   <= 4'd0;
            r_right  <= 4'd0;
            r_found  <= 1'b0;
            r_mask   <= 5'd0;
            r_acc    <= 6'd0;
        end else begin
            r_state  <= w_state_d;
            r_row    <= w_row_d;
            r_col    <= w_col_d;
            r_dir    <= w_dir_d;
            r_step   <= w_step_d;
            r_clear  <= w_clear_d;
            r_inv    <= w_inv_d;
            r_frame  <= w_frame_d;
            r_alive  <= w_alive_d;
            r_snap   <= w_snap_d;
            r_scan_c <= w_scan_c_d;
            r_left   <= w_left_d;
            r_right  <= w_right_d;
            r_found  <= w_found_d;
            r_mask   <= w_mask_d;
            r_acc    <= w_acc_d;
        end
    end

    assign AliensRow = r_row;
    assign AliensCol = r_col;
    assign Dir       = r_dir;
    assign StepPulse = r_step;
    assign WaveClear = r_clear;
    assign Invaded   = r_inv;

endmodule

// File: tb/tb_alien_march_ctrl.sv
// Directed bench for alien_march_ctrl. Inputs are driven and outputs sampled
// on the falling clock edge; every task ends on a falling edge.
module tb_alien_march_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        FrameTick = 1'b0;
    logic [49:0] Aliens_Grid = '1;
    logic [8:0]  PlayerRow = 9'd511;
    logic [8:0]  AliensRow;
    logic [9:0]  AliensCol;
    logic        Dir;
    logic        StepPulse;
    logic        WaveClear;
    logic        Invaded;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [49:0] FullGrid = '1;

    always #5 Clk = ~Clk;

    alien_march_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .FrameTick   (FrameTick),
        .Aliens_Grid (Aliens_Grid),
        .PlayerRow   (PlayerRow),
        .AliensRow   (AliensRow),
        .AliensCol   (AliensCol),
        .Dir         (Dir),
        .StepPulse   (StepPulse),
        .WaveClear   (WaveClear),
        .Invaded     (Invaded)
    );

    // Hold FrameTick high until a StepPulse is seen or the budget runs out.
    task automatic run_step(input int budget, output int cycles, output bit seen);
        cycles = 0;
        seen = 1'b0;
        FrameTick = 1'b1;
        while (!seen && cycles < budget) begin
            @(negedge Clk);
            cycles++;
            if (StepPulse === 1'b1) seen = 1'b1;
        end
        FrameTick = 1'b0;
    endtask

    task automatic do_start();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic test_reset();
        bit bad;
        Reset = 1'b1;
        #2 Reset = 1'b0;
        #1;
        n_checks++; if (AliensRow !== 9'd32) $display("FAIL reset_row: got %0d expected 32", AliensRow); else n_pass++;
        n_checks++; if (AliensCol !== 10'd64) $display("FAIL reset_col: got %0d expected 64", AliensCol); else n_pass++;
        n_checks++; if (Dir !== 1'b1) $display("FAIL reset_dir: got %b expected 1", Dir); else n_pass++;
        n_checks++; if ({StepPulse, WaveClear, Invaded} !== 3'b000)
            $display("FAIL reset_flags: got %b expected 000", {StepPulse, WaveClear, Invaded}); else n_pass++;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            FrameTick = 1'b1;
            @(negedge Clk);
            FrameTick = 1'b0;
            @(negedge Clk);
            if (AliensRow !== 9'd32 || AliensCol !== 10'd64 || Dir !== 1'b1 ||
                {StepPulse, WaveClear, Invaded} !== 3'b000) bad = 1'b1;
        end
        repeat (20) begin
            @(negedge Clk);
            if (AliensCol !== 10'd64 || StepPulse !== 1'b0) bad = 1'b1;
        end
        n_checks++; if (bad) $display("FAIL idle_ignores_ticks: got change expected none"); else n_pass++;
    endtask

    task automatic test_first_step();
        bit bad;
        int lat;
        Aliens_Grid = FullGrid;
        do_start();
        bad = 1'b0;
        for (int k = 0; k < 12; k++) begin
            FrameTick = 1'b1;
            @(negedge Clk);
            FrameTick = 1'b0;
            @(negedge Clk);
            if (StepPulse !== 1'b0 || AliensCol !== 10'd64) bad = 1'b1;
        end
        n_checks++; if (bad) $display("FAIL ticks_1_to_12: got move expected none"); else n_pass++;
        FrameTick = 1'b1;
        lat = 0;
        for (int k = 1; k <= 30 && lat == 0; k++) begin
            @(negedge Clk);
            FrameTick = 1'b0;
            if (StepPulse === 1'b1) lat = k;
        end
        n_checks++; if (lat != 12) $display("FAIL step_latency: got %0d expected 12", lat); else n_pass++;
        n_checks++; if (AliensCol !== 10'd68) $display("FAIL first_step_col: got %0d expected 68", AliensCol); else n_pass++;
        @(negedge Clk);
        n_checks++; if (StepPulse !== 1'b0) $display("FAIL pulse_width: got %b expected 0", StepPulse); else n_pass++;
    endtask

    task automatic test_edge_full();
        int cyc;
        bit seen;
        bit timeout;
        int first_cyc;
        timeout = 1'b0;
        first_cyc = 0;
        for (int s = 0; s < 63; s++) begin
            run_step(40, cyc, seen);
            if (s == 0) first_cyc = cyc;
            if (!seen) timeout = 1'b1;
        end
        n_checks++; if (timeout) $display("FAIL edge_run_timeout: got no pulse expected pulse"); else n_pass++;
        n_checks++; if (first_cyc != 24) $display("FAIL interval13_cycles: got %0d expected 24", first_cyc); else n_pass++;
        n_checks++; if (AliensCol !== 10'd320 || AliensRow !== 9'd32 || Dir !== 1'b1)
            $display("FAIL at_right_edge: got col %0d row %0d dir %b expected 320 32 1", AliensCol, AliensRow, Dir); else n_pass++;
        run_step(40, cyc, seen);
        n_checks++; if (!seen || AliensRow !== 9'd48 || AliensCol !== 10'd320 || Dir !== 1'b0)
            $display("FAIL right_descend: got col %0d row %0d dir %b expected 320 48 0", AliensCol, AliensRow, Dir); else n_pass++;
        run_step(40, cyc, seen);
        n_checks++; if (!seen || AliensCol !== 10'd316 || AliensRow !== 9'd48)
            $display("FAIL left_after_descend: got col %0d row %0d expected 316 48", AliensCol, AliensRow); else n_pass++;
    endtask

    task automatic test_single_alien();
        int cyc;
        bit seen;
        bit timeout;
        Aliens_Grid = 50'd1;
        do_start();
        timeout = 1'b0;
        run_step(40, cyc, seen);
        n_checks++; if (!seen || AliensCol !== 10'd68) $display("FAIL single_first: got col %0d expected 68", AliensCol); else n_pass++;
        run_step(40, cyc, seen);
        n_checks++; if (cyc != 12) $display("FAIL interval1_cycles: got %0d expected 12", cyc); else n_pass++;
        for (int s = 0; s < 134; s++) begin
            run_step(40, cyc, seen);
            if (!seen) timeout = 1'b1;
        end
        n_checks++; if (timeout || AliensCol !== 10'd608 || AliensRow !== 9'd32 || Dir !== 1'b1)
            $display("FAIL single_right_limit: got col %0d row %0d dir %b expected 608 32 1", AliensCol, AliensRow, Dir); else n_pass++;
        run_step(40, cyc, seen);
        n_checks++; if (!seen || AliensCol !== 10'd608 || AliensRow !== 9'd48 || Dir !== 1'b0)
            $display("FAIL single_right_descend: got col %0d row %0d dir %b expected 608 48 0", AliensCol, AliensRow, Dir); else n_pass++;
        for (int s = 0; s < 152; s++) begin
            run_step(40, cyc, seen);
            if (!seen) timeout = 1'b1;
        end
        n_checks++; if (timeout || AliensCol !== 10'd0 || AliensRow !== 9'd48)
            $display("FAIL single_left_limit: got col %0d row %0d expected 0 48", AliensCol, AliensRow); else n_pass++;
        run_step(40, cyc, seen);
        n_checks++; if (!seen || AliensCol !== 10'd0 || AliensRow !== 9'd64 || Dir !== 1'b1)
            $display("FAIL single_left_descend: got col %0d row %0d dir %b expected 0 64 1", AliensCol, AliensRow, Dir); else n_pass++;
    endtask

    task automatic test_wave_clear();
        int clr_at;
        bit pulsed;
        Aliens_Grid = FullGrid;
        do_start();
        Aliens_Grid = '0;
        clr_at = 0;
        pulsed = 1'b0;
        FrameTick = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge Clk);
            if (StepPulse === 1'b1) pulsed = 1'b1;
            if (WaveClear === 1'b1 && clr_at == 0) clr_at = k;
        end
        FrameTick = 1'b0;
        n_checks++; if (clr_at != 24) $display("FAIL clear_latency: got %0d expected 24", clr_at); else n_pass++;
        n_checks++; if (pulsed) $display("FAIL clear_no_pulse: got pulse expected none"); else n_pass++;
        n_checks++; if (WaveClear !== 1'b1 || AliensCol !== 10'd64 || AliensRow !== 9'd32 || Dir !== 1'b1)
            $display("FAIL clear_frozen: got wc %b col %0d row %0d dir %b expected 1 64 32 1",
                     WaveClear, AliensCol, AliensRow, Dir); else n_pass++;
        Aliens_Grid = FullGrid;
        do_start();
        n_checks++; if (WaveClear !== 1'b0 || AliensCol !== 10'd64 || AliensRow !== 9'd32)
            $display("FAIL clear_restart: got wc %b col %0d row %0d expected 0 64 32", WaveClear, AliensCol, AliensRow); else n_pass++;
    endtask

    task automatic test_invade();
        int cyc;
        bit seen;
        int steps;
        bit ok65;
        bit ok146;
        bit pulsed;
        PlayerRow = 9'd200;
        Aliens_Grid = FullGrid;
        do_start();
        steps = 0;
        ok65 = 1'b0;
        ok146 = 1'b0;
        for (int s = 1; s <= 300; s++) begin
            run_step(40, cyc, seen);
            if (!seen) break;
            steps = s;
            if (s == 65)  ok65  = (AliensRow === 9'd48) && (Invaded === 1'b0);
            if (s == 146) ok146 = (AliensRow === 9'd64) && (Invaded === 1'b0);
            if (Invaded === 1'b1) break;
        end
        n_checks++; if (!ok65) $display("FAIL descend_48: got bad state expected row 48 not invaded"); else n_pass++;
        n_checks++; if (!ok146) $display("FAIL descend_64: got bad state expected row 64 not invaded"); else n_pass++;
        n_checks++; if (steps != 227) $display("FAIL invade_step: got %0d expected 227", steps); else n_pass++;
        n_checks++; if (Invaded !== 1'b1 || StepPulse !== 1'b1 || AliensRow !== 9'd80 ||
                        AliensCol !== 10'd320 || Dir !== 1'b0)
            $display("FAIL invade_state: got inv %b sp %b row %0d col %0d dir %b expected 1 1 80 320 0",
                     Invaded, StepPulse, AliensRow, AliensCol, Dir); else n_pass++;
        pulsed = 1'b0;
        FrameTick = 1'b1;
        repeat (40) begin
            @(negedge Clk);
            if (StepPulse === 1'b1 || AliensRow !== 9'd80 || AliensCol !== 10'd320) pulsed = 1'b1;
        end
        FrameTick = 1'b0;
        n_checks++; if (pulsed || Invaded !== 1'b1)
            $display("FAIL invade_frozen: got change or inv %b expected frozen inv 1", Invaded); else n_pass++;
        PlayerRow = 9'd511;
    endtask

    task automatic test_reset_midscan();
        int cyc;
        bit seen;
        bit pulsed;
        Aliens_Grid = FullGrid;
        do_start();
        run_step(40, cyc, seen);
        n_checks++; if (!seen || AliensCol !== 10'd68) $display("FAIL midscan_prestep: got col %0d expected 68", AliensCol); else n_pass++;
        FrameTick = 1'b1;
        repeat (17) @(negedge Clk);
        Reset = 1'b0;
        #1;
        n_checks++; if (AliensCol !== 10'd64 || AliensRow !== 9'd32 || Dir !== 1'b1 ||
                        {StepPulse, WaveClear, Invaded} !== 3'b000)
            $display("FAIL midscan_reset: got col %0d row %0d dir %b flags %b expected 64 32 1 000",
                     AliensCol, AliensRow, Dir, {StepPulse, WaveClear, Invaded}); else n_pass++;
        pulsed = 1'b0;
        repeat (2) begin
            @(negedge Clk);
            if (StepPulse === 1'b1) pulsed = 1'b1;
        end
        Reset = 1'b1;
        repeat (30) begin
            @(negedge Clk);
            if (StepPulse === 1'b1 || AliensCol !== 10'd64) pulsed = 1'b1;
        end
        FrameTick = 1'b0;
        n_checks++; if (pulsed) $display("FAIL midscan_no_pulse: got pulse expected none"); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_step();
        test_edge_full();
        test_single_alien();
        test_wave_clear();
        test_invade();
        test_reset_midscan();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
